mem_stage: RTL and testbench



---
 rtl/mem_pkg.sv | 55 +++++
 rtl/mem_stage_if.sv | 21 ++
 rtl/load_align.sv | 30 +++
 rtl/mem_stage.sv | 135 +++++++++++++
 tb/tb_mem_stage.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: funct3 codes, FSM state
// type and the small encode/decode helpers used by the stage and its aligner.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Halfword accesses need an even address, word accesses a 4-byte aligned one.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Any access that must retire immediately with a fault instead of touching memory.
  function automatic logic access_fault(input logic rd_op, input logic wr_op,
                                        input logic [2:0] f3, input logic [1:0] off);
    logic bad_load;
    logic bad_store;
    bad_load  = rd_op && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    bad_store = wr_op && !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
    return (rd_op && wr_op) || bad_load || bad_store ||
           ((rd_op || wr_op) && misaligned(f3, off));
  endfunction

  // Byte-enable lanes for an access of the given width at the given offset.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the store operand so the addressed lanes carry it whatever the offset.
  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] data);
    case (f3[1:0])
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/grant/response bus between the MEM stage and the memory.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/load_align.sv
// Selects the addressed byte/half of a load response and sign- or zero-extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{off, 3'b000} +: 8];
  assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];

  // Extend the selected lane according to the load width and signedness.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves result unassigned (no latch).
    result = rdata;
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result = {24'h0, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result = {16'h0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: one operation at a time, drives the dmem bus for loads and
// stores, stalls EX while a transaction is outstanding, registers MEM/WB fields.
module mem_stage
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [31:0]       ex_result,
  input  logic [31:0]       store_data,
  input  logic [2:0]        funct3,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [4:0]        rd,
  input  logic              werf,
  input  logic              wb_sel,
  mem_stage_if.master       dmem,
  output logic              wb_valid,
  output logic [31:0]       wb_mem_data,
  output logic [31:0]       wb_ex_result,
  output logic [4:0]        wb_rd,
  output logic              wb_werf,
  output logic              wb_sel_q,
  output logic              mem_fault
);

  state_t      state;
  logic [31:0] op_addr;
  logic [2:0]  op_f3;
  logic [4:0]  op_rd;
  logic        op_werf;
  logic        op_sel;
  logic [31:0] load_data;
  logic        is_mem;
  logic        fault;

  assign ex_ready = (state == ST_IDLE);
  assign is_mem   = mem_rd | mem_wr;
  assign fault    = access_fault(mem_rd, mem_wr, funct3, ex_result[1:0]);

  load_align u_align (
    .rdata  (dmem.dmem_rdata),
    .off    (op_addr[1:0]),
    .funct3 (op_f3),
    .result (load_data)
  );

  // FSM, dmem request registers and MEM/WB output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      op_addr         <= '0;
      op_f3           <= '0;
      op_rd           <= '0;
      op_werf         <= 1'b0;
      op_sel          <= 1'b0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
      dmem.dmem_be    <= '0;
      wb_valid        <= 1'b0;
      wb_mem_data     <= '0;
      wb_ex_result    <= '0;
      wb_rd           <= '0;
      wb_werf         <= 1'b0;
      wb_sel_q        <= 1'b0;
      mem_fault       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; these pulse defaults are overridden later in the same block.
      wb_valid  <= 1'b0;
      wb_werf   <= 1'b0;
      mem_fault <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ex_valid) begin
            op_addr <= ex_result;
            op_f3   <= funct3;
            op_rd   <= rd;
            op_werf <= werf;
            op_sel  <= wb_sel;
            if (is_mem && !fault) begin
              state           <= ST_REQ;
              dmem.dmem_req   <= 1'b1;
              dmem.dmem_we    <= mem_wr;
              dmem.dmem_addr  <= {ex_result[31:2], 2'b00};
              dmem.dmem_be    <= store_be(funct3, ex_result[1:0]);
              dmem.dmem_wdata <= store_wdata(funct3, store_data);
            end else begin
              // Non-memory and faulting ops retire straight from IDLE.
              wb_valid     <= 1'b1;
              wb_mem_data  <= '0;
              wb_ex_result <= ex_result;
              wb_rd        <= rd;
              wb_werf      <= werf & ~fault;
              wb_sel_q     <= wb_sel;
              mem_fault    <= fault;
            end
          end
        end
        ST_REQ: begin
          if (dmem.dmem_gnt) begin
            dmem.dmem_req <= 1'b0;
            dmem.dmem_we  <= 1'b0;
            if (dmem.dmem_we) begin
              state        <= ST_IDLE;
              wb_valid     <= 1'b1;
              wb_mem_data  <= '0;
              wb_ex_result <= op_addr;
              wb_rd        <= op_rd;
              wb_werf      <= op_werf;
              wb_sel_q     <= op_sel;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (dmem.dmem_rvalid) begin
            state        <= ST_IDLE;
            wb_valid     <= 1'b1;
            wb_mem_data  <= load_data;
            wb_ex_result <= op_addr;
            wb_rd        <= op_rd;
            wb_werf      <= op_werf;
            wb_sel_q     <= op_sel;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: memory side driven by hand, expectations hand-computed.
module tb_mem_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_result;
  logic [31:0] store_data;
  logic [2:0]  funct3;
  logic        mem_rd;
  logic        mem_wr;
  logic [4:0]  rd;
  logic        werf;
  logic        wb_sel;
  logic        wb_valid;
  logic [31:0] wb_mem_data;
  logic [31:0] wb_ex_result;
  logic [4:0]  wb_rd;
  logic        wb_werf;
  logic        wb_sel_q;
  logic        mem_fault;

  logic [31:0] la_rdata;
  logic [1:0]  la_off;
  logic [2:0]  la_f3;
  logic [31:0] la_result;

  int errors = 0;
  int checks = 0;
  int low_cycles;

  mem_stage_if dmem ();

  mem_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_result    (ex_result),
    .store_data   (store_data),
    .funct3       (funct3),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .rd           (rd),
    .werf         (werf),
    .wb_sel       (wb_sel),
    .dmem         (dmem),
    .wb_valid     (wb_valid),
    .wb_mem_data  (wb_mem_data),
    .wb_ex_result (wb_ex_result),
    .wb_rd        (wb_rd),
    .wb_werf      (wb_werf),
    .wb_sel_q     (wb_sel_q),
    .mem_fault    (mem_fault)
  );

  load_align u_la (
    .rdata  (la_rdata),
    .off    (la_off),
    .funct3 (la_f3),
    .result (la_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic present(input logic [31:0] res, input logic [31:0] sd, input logic [2:0] f3,
                         input logic rdm, input logic wrm, input logic [4:0] r,
                         input logic rf, input logic sel);
    ex_valid   = 1'b1;
    ex_result  = res;
    store_data = sd;
    funct3     = f3;
    mem_rd     = rdm;
    mem_wr     = wrm;
    rd         = r;
    werf       = rf;
    wb_sel     = sel;
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] rdata, input logic [31:0] exp);
    present(addr, 32'h0, f3, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1);
    step();
    ex_valid = 1'b0;
    check({tag, " req"}, dmem.dmem_req, 1);
    check({tag, " we"}, dmem.dmem_we, 0);
    check({tag, " addr"}, dmem.dmem_addr, {addr[31:2], 2'b00});
    dmem.dmem_gnt = 1'b1;
    step();
    dmem.dmem_gnt = 1'b0;
    check({tag, " wait req"}, dmem.dmem_req, 0);
    check({tag, " wait ready"}, ex_ready, 0);
    dmem.dmem_rvalid = 1'b1;
    dmem.dmem_rdata  = rdata;
    step();
    dmem.dmem_rvalid = 1'b0;
    check({tag, " wb_valid"}, wb_valid, 1);
    check({tag, " data"}, wb_mem_data, exp);
    check({tag, " ex_result"}, wb_ex_result, addr);
    check({tag, " rd"}, wb_rd, 9);
    check({tag, " werf"}, wb_werf, 1);
    check({tag, " sel"}, wb_sel_q, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    ex_valid = 1'b0; ex_result = '0; store_data = '0; funct3 = '0;
    mem_rd = 1'b0; mem_wr = 1'b0; rd = '0; werf = 1'b0; wb_sel = 1'b0;
    dmem.dmem_gnt = 1'b0; dmem.dmem_rvalid = 1'b0; dmem.dmem_rdata = '0;

    // Aligner standalone.
    la_rdata = 32'h7F00_0000; la_off = 2'd3; la_f3 = F3_B;  #1;
    check("la lb off3", la_result, 32'h0000_007F);
    la_rdata = 32'h0000_FF00; la_off = 2'd1; la_f3 = F3_BU; #1;
    check("la lbu off1", la_result, 32'h0000_00FF);
    la_rdata = 32'h1234_ABCD; la_off = 2'd0; la_f3 = F3_H;  #1;
    check("la lh off0", la_result, 32'hFFFF_ABCD);

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst ready", ex_ready, 1);
    check("rst req", dmem.dmem_req, 0);
    check("rst we", dmem.dmem_we, 0);
    check("rst addr", dmem.dmem_addr, 0);
    check("rst be", dmem.dmem_be, 0);
    check("rst wdata", dmem.dmem_wdata, 0);
    check("rst wb_valid", wb_valid, 0);
    check("rst werf", wb_werf, 0);
    check("rst mem_data", wb_mem_data, 0);
    check("rst fault", mem_fault, 0);
    rst_n = 1'b1;
    step();

    // ADD retires next cycle with no dmem traffic.
    present(32'h0000_1234, 32'h0, 3'b000, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
    step();
    ex_valid = 1'b0;
    check("add wb_valid", wb_valid, 1);
    check("add ex_result", wb_ex_result, 32'h0000_1234);
    check("add rd", wb_rd, 5);
    check("add werf", wb_werf, 1);
    check("add mem_data", wb_mem_data, 0);
    check("add req", dmem.dmem_req, 0);
    check("add ready", ex_ready, 1);
    step();
    check("add pulse end", wb_valid, 0);
    check("add werf end", wb_werf, 0);

    // SB at 0x103 with grant withheld for three cycles.
    present(32'h0000_0103, 32'h0000_00AB, F3_B, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    step();
    ex_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("sb req held", dmem.dmem_req, 1);
      check("sb ready low", ex_ready, 0);
      check("sb no retire", wb_valid, 0);
      step();
    end
    check("sb req", dmem.dmem_req, 1);
    check("sb we", dmem.dmem_we, 1);
    check("sb addr", dmem.dmem_addr, 32'h0000_0100);
    check("sb be", dmem.dmem_be, 4'b1000);
    check("sb wdata", dmem.dmem_wdata, 32'hABAB_ABAB);
    dmem.dmem_gnt = 1'b1;
    step();
    dmem.dmem_gnt = 1'b0;
    check("sb retire", wb_valid, 1);
    check("sb req drop", dmem.dmem_req, 0);
    check("sb mem_data", wb_mem_data, 0);
    check("sb ready", ex_ready, 1);

    // SH at 0x106: upper half lanes.
    present(32'h0000_0106, 32'h1234_BEEF, F3_H, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    step();
    ex_valid = 1'b0;
    check("sh be", dmem.dmem_be, 4'b1100);
    check("sh wdata", dmem.dmem_wdata, 32'hBEEF_BEEF);
    dmem.dmem_gnt = 1'b1;
    step();
    dmem.dmem_gnt = 1'b0;
    check("sh retire", wb_valid, 1);

    // Load alignment.
    do_load("lb",  32'h0000_0202, F3_B,  32'h0080_0000, 32'hFFFF_FF80);
    do_load("lbu", 32'h0000_0202, F3_BU, 32'h0080_0000, 32'h0000_0080);
    do_load("lh",  32'h0000_0202, F3_H,  32'h8001_0000, 32'hFFFF_8001);
    do_load("lhu", 32'h0000_0202, F3_HU, 32'h8001_0000, 32'h0000_8001);
    do_load("lw",  32'h0000_0300, F3_W,  32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // Misaligned LW faults immediately.
    present(32'h0000_0301, 32'h0, F3_W, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1);
    step();
    ex_valid = 1'b0;
    check("lw mis wb_valid", wb_valid, 1);
    check("lw mis fault", mem_fault, 1);
    check("lw mis werf", wb_werf, 0);
    check("lw mis req", dmem.dmem_req, 0);
    check("lw mis ready", ex_ready, 1);
    step();
    check("lw mis req after", dmem.dmem_req, 0);
    check("lw mis fault end", mem_fault, 0);

    // Odd SH and a read+write op also fault.
    present(32'h0000_0101, 32'h0, F3_H, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    step();
    check("sh mis fault", mem_fault, 1);
    present(32'h0000_0100, 32'h0, F3_W, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0);
    step();
    ex_valid = 1'b0;
    check("rdwr fault", mem_fault, 1);
    check("rdwr req", dmem.dmem_req, 0);
    step();

    // ADD, LW (gnt immediate, rvalid two cycles later), ADD.
    low_cycles = 0;
    present(32'h0000_0011, 32'h0, 3'b000, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0);
    step();
    check("seq add1 valid", wb_valid, 1);
    check("seq add1 rd", wb_rd, 1);
    if (!ex_ready) low_cycles++;
    present(32'h0000_0500, 32'h0, F3_W, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1);
    dmem.dmem_gnt = 1'b1;
    step();
    check("seq req valid", wb_valid, 0);
    if (!ex_ready) low_cycles++;
    present(32'h0000_0033, 32'h0, 3'b000, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
    step();
    dmem.dmem_gnt = 1'b0;
    check("seq wait1 valid", wb_valid, 0);
    if (!ex_ready) low_cycles++;
    step();
    check("seq wait2 valid", wb_valid, 0);
    if (!ex_ready) low_cycles++;
    dmem.dmem_rvalid = 1'b1;
    dmem.dmem_rdata  = 32'hCAFE_F00D;
    step();
    dmem.dmem_rvalid = 1'b0;
    check("seq lw valid", wb_valid, 1);
    check("seq lw rd", wb_rd, 2);
    check("seq lw data", wb_mem_data, 32'hCAFE_F00D);
    if (!ex_ready) low_cycles++;
    step();
    ex_valid = 1'b0;
    check("seq add2 valid", wb_valid, 1);
    check("seq add2 rd", wb_rd, 3);
    check("seq add2 ex_result", wb_ex_result, 32'h0000_0033);
    if (!ex_ready) low_cycles++;
    step();
    check("seq idle", wb_valid, 0);
    check("seq low cycles", low_cycles, 3);

    // Reset while waiting for a load response; a late response is ignored.
    present(32'h0000_0600, 32'h0, F3_W, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
    step();
    ex_valid = 1'b0;
    dmem.dmem_gnt = 1'b1;
    step();
    dmem.dmem_gnt = 1'b0;
    check("rstw in wait", ex_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rstw ready", ex_ready, 1);
    check("rstw req", dmem.dmem_req, 0);
    check("rstw wb_valid", wb_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dmem.dmem_rvalid = 1'b1;
    dmem.dmem_rdata  = 32'h0000_0001;
    step();
    dmem.dmem_rvalid = 1'b0;
    check("rstw late rvalid", wb_valid, 0);
    check("rstw late werf", wb_werf, 0);
    check("rstw idle", ex_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
